mult_result_checker: RTL and testbench

MULT_RESULT_CHECKER -- requirements
Module: mult_result_checker

---
 rtl/mult_result_checker.sv | 147 ++++++++++++++
 tb/tb_mult_result_checker.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_checker.sv
// mult_result_checker
//   Runs alongside an A_W x B_W unsigned multiplier under test. The block
//   feeds each operand beat through a LATENCY-deep pipeline with its
//   reference product. When a beat reaches the pipeline end, the block
//   compares the reference product with z_in, counts the sample and, on a
//   mismatch, records the error.
//
// Handshake: there is no backpressure. A beat is taken when in_valid is high
//   at a rising clk edge while the FSM is in RUN. The product for that beat
//   must be on z_in exactly LATENCY cycles later.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   start             begin a run (IDLE/DONE only); clears all results
//   stop              end of stimulus; move to DRAIN
//   in_valid          operand beat valid on a_in/b_in
//   a_in, b_in        unsigned operands
//   z_in              product from the multiplier under test
//   busy, done        state decode (RUN|DRAIN, DONE)
//   err_flag          sticky mismatch flag
//   sample_cnt        products compared (saturating)
//   err_cnt           mismatches seen (saturating)
//   first_a/b/z/exp   operands, observed and expected product of the first mismatch
module mult_result_checker #(
  parameter int A_W     = 20,
  parameter int B_W     = 18,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic [A_W-1:0]     a_in,
  input  logic [B_W-1:0]     b_in,
  input  logic [A_W+B_W-1:0] z_in,
  output logic               busy,
  output logic               done,
  output logic               err_flag,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [A_W-1:0]     first_a,
  output logic [B_W-1:0]     first_b,
  output logic [A_W+B_W-1:0] first_z,
  output logic [A_W+B_W-1:0] first_exp
);

  localparam int P_W = A_W + B_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_n;

  logic [LATENCY-1:0] vld, vld_n;
  logic [A_W-1:0]     pa [LATENCY];
  logic [B_W-1:0]     pb [LATENCY];
  logic [P_W-1:0]     pe [LATENCY];

  logic           accept;
  logic           start_ok;
  logic           cmp;
  logic           mismatch;
  logic [P_W-1:0] prod;

  assign prod     = P_W'(a_in) * P_W'(b_in);
  assign accept   = (state == RUN) && in_valid;
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign cmp      = vld[LATENCY-1];
  assign mismatch = cmp && (z_in != pe[LATENCY-1]);

  // Valid bits after this edge's shift. The DRAIN exit decision looks at
  // these, so the FSM leaves DRAIN on the same edge that retires the last beat.
  always_comb begin
    vld_n    = '0;
    vld_n[0] = accept;
    for (int i = 1; i < LATENCY; i++) vld_n[i] = vld[i-1];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (stop) state_n = DRAIN;
      DRAIN:   if (vld_n == '0) state_n = DONE;
      DONE:    if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vld        <= '0;
      err_flag   <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      first_a    <= '0;
      first_b    <= '0;
      first_z    <= '0;
      first_exp  <= '0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        vld        <= '0;
        err_flag   <= 1'b0;
        sample_cnt <= '0;
        err_cnt    <= '0;
        first_a    <= '0;
        first_b    <= '0;
        first_z    <= '0;
        first_exp  <= '0;
      end else begin
        vld <= vld_n;
        if (cmp && (sample_cnt != '1)) sample_cnt <= sample_cnt + 1'b1;
        if (mismatch) begin
          err_flag <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          // err_cnt saturates rather than wrapping, so zero means no earlier error.
          if (err_cnt == '0) begin
            first_a   <= pa[LATENCY-1];
            first_b   <= pb[LATENCY-1];
            first_z   <= z_in;
            first_exp <= pe[LATENCY-1];
          end
        end
      end
    end
  end

  // The data stages shift on every edge. Only the valid bits decide what
  // is compared, so these registers need no reset.
  always_ff @(posedge clk) begin
    pa[0] <= a_in;
    pb[0] <= b_in;
    pe[0] <= prod;
    for (int i = 1; i < LATENCY; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
      pe[i] <= pe[i-1];
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_result_checker.sv
// Bench for mult_result_checker: dut1 (LATENCY=1, default widths) and
// dut3 (LATENCY=3, 4-bit counters so that saturation is reachable).
module tb_mult_result_checker;

  localparam int A_W = 20;
  localparam int B_W = 18;
  localparam int P_W = A_W + B_W;
  localparam int C1  = 16;
  localparam int C3  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- dut1 ----------------
  logic           start1 = 0, stop1 = 0, iv1 = 0;
  logic [A_W-1:0] a1 = '0;
  logic [B_W-1:0] b1 = '0;
  logic [P_W-1:0] z1_d = '0, z1_in = '0;
  logic           busy1, done1, flag1;
  logic [C1-1:0]  s1, e1;
  logic [A_W-1:0] fa1;
  logic [B_W-1:0] fb1;
  logic [P_W-1:0] fz1, fe1;

  // Multiplier model: z1_d is the product attached to a beat; it appears on z1_in one cycle later.
  always @(posedge clk) z1_in <= z1_d;

  mult_result_checker #(.A_W(A_W), .B_W(B_W), .LATENCY(1), .CNT_W(C1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop(stop1), .in_valid(iv1),
    .a_in(a1), .b_in(b1), .z_in(z1_in), .busy(busy1), .done(done1),
    .err_flag(flag1), .sample_cnt(s1), .err_cnt(e1), .first_a(fa1),
    .first_b(fb1), .first_z(fz1), .first_exp(fe1));

  // ---------------- dut3 ----------------
  logic           start3 = 0, stop3 = 0, iv3 = 0;
  logic [A_W-1:0] a3 = '0;
  logic [B_W-1:0] b3 = '0;
  logic [P_W-1:0] z3_d = '0, z3_in = '0;
  logic [P_W-1:0] zs3_0 = '0, zs3_1 = '0;
  logic           busy3, done3, flag3;
  logic [C3-1:0]  s3, e3;
  logic [A_W-1:0] fa3;
  logic [B_W-1:0] fb3;
  logic [P_W-1:0] fz3, fe3;

  always @(posedge clk) begin
    zs3_0 <= z3_d;
    zs3_1 <= zs3_0;
    z3_in <= zs3_1;
  end

  mult_result_checker #(.A_W(A_W), .B_W(B_W), .LATENCY(3), .CNT_W(C3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .stop(stop3), .in_valid(iv3),
    .a_in(a3), .b_in(b3), .z_in(z3_in), .busy(busy3), .done(done3),
    .err_flag(flag3), .sample_cnt(s3), .err_cnt(e3), .first_a(fa3),
    .first_b(fb3), .first_z(fz3), .first_exp(fe3));

  // ---------------- dut1 scoreboard ----------------
  // One entry per accepted beat: 1 if that beat must count as a mismatch.
  logic [0:0]    exp_q[$];
  logic [C1-1:0] prev_s = '0, prev_e = '0;
  logic [0:0]    exp_bit;

  always @(negedge clk) begin
    if (!reset && (s1 == prev_s + 1'b1)) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected_sample: sample_cnt=%0d with no beat expected", s1);
      end else begin
        exp_bit = exp_q.pop_front();
        tests++;
        if (e1 !== prev_e + C1'(exp_bit)) begin
          fails++;
          $display("FAIL sb_err_step: err_cnt=%0d expected %0d", e1, prev_e + C1'(exp_bit));
        end
      end
    end
    prev_s = s1;
    prev_e = e1;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat1(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                       input logic [P_W-1:0] z);
    logic [P_W-1:0] ref_p;
    ref_p = P_W'(a) * P_W'(b);
    a1 = a; b1 = b; z1_d = z; iv1 = 1;
    exp_q.push_back(z != ref_p);
    tick();
    iv1 = 0;
  endtask

  task automatic beat3(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                       input logic [P_W-1:0] z);
    a3 = a; b3 = b; z3_d = z; iv3 = 1;
    tick();
    iv3 = 0;
  endtask

  task automatic pulse_start1();
    start1 = 1; tick(); start1 = 0;
  endtask

  task automatic pulse_start3();
    start3 = 1; tick(); start3 = 0;
  endtask

  task automatic drain1();
    int n;
    stop1 = 1; tick(); stop1 = 0;
    n = 0;
    while (!done1 && n < 20) begin tick(); n++; end
    tests++;
    if (done1 !== 1'b1) begin
      fails++;
      $display("FAIL drain1_done: done=%b after %0d cycles, required 1", done1, n);
    end
  endtask

  task automatic drain3();
    int n;
    stop3 = 1; tick(); stop3 = 0;
    n = 0;
    while (!done3 && n < 20) begin tick(); n++; end
    tests++;
    if (done3 !== 1'b1) begin
      fails++;
      $display("FAIL drain3_done: done=%b after %0d cycles, required 1", done3, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; start1 = 1; iv1 = 1; start3 = 1;
    tick(); tick();
    reset = 0; start1 = 0; iv1 = 0; start3 = 0;
    tests++;
    if ({busy1, done1, flag1, s1, e1, fa1, fb1, fz1, fe1} !== '0) begin
      fails++;
      $display("FAIL reset_dut1: busy=%b done=%b flag=%b s=%0d e=%0d, required all 0",
               busy1, done1, flag1, s1, e1);
    end
    tests++;
    if ({busy3, done3, flag3, s3, e3, fa3, fb3, fz3, fe3} !== '0) begin
      fails++;
      $display("FAIL reset_dut3: busy=%b done=%b flag=%b s=%0d e=%0d, required all 0",
               busy3, done3, flag3, s3, e3);
    end
  endtask

  task automatic test_basic();
    pulse_start1();
    tests++;
    if (busy1 !== 1'b1) begin fails++; $display("FAIL basic_busy: busy=%b required 1", busy1); end
    for (int i = 0; i < 4; i++) beat1(20'd3, 18'd5, 38'd15);
    tick(); tick();
    tests++;
    if (s1 !== 16'd4 || e1 !== 16'd0 || flag1 !== 1'b0) begin
      fails++;
      $display("FAIL basic_counts: s=%0d e=%0d flag=%b required 4 0 0", s1, e1, flag1);
    end
    drain1();
  endtask

  task automatic test_max_operands();
    pulse_start1();
    tests++;
    if (s1 !== 16'd0) begin fails++; $display("FAIL max_clear: sample_cnt=%0d required 0", s1); end
    beat1(20'hFFFFF, 18'h3FFFF, 38'h3FFFEC0001);
    beat1(20'hFFFFF, 18'h3FFFF, 38'h3FFFEC0000);
    tick(); tick();
    tests++;
    if (s1 !== 16'd2 || e1 !== 16'd1 || flag1 !== 1'b1) begin
      fails++;
      $display("FAIL max_counts: s=%0d e=%0d flag=%b required 2 1 1", s1, e1, flag1);
    end
    tests++;
    if (fe1 !== 38'h3FFFEC0001 || fz1 !== 38'h3FFFEC0000 || fa1 !== 20'hFFFFF || fb1 !== 18'h3FFFF) begin
      fails++;
      $display("FAIL max_first: a=%h b=%h z=%h exp=%h required fffff 3ffff 3fffec0000 3fffec0001",
               fa1, fb1, fz1, fe1);
    end
    drain1();
  endtask

  task automatic test_multi_err();
    pulse_start1();
    beat1(20'd2, 18'd2, 38'd5);
    beat1(20'd7, 18'd7, 38'd0);
    tick(); tick();
    tests++;
    if (e1 !== 16'd2 || fa1 !== 20'd2 || fb1 !== 18'd2 || fz1 !== 38'd5 || fe1 !== 38'd4) begin
      fails++;
      $display("FAIL multi_err: e=%0d a=%0d b=%0d z=%0d exp=%0d required 2 2 2 5 4",
               e1, fa1, fb1, fz1, fe1);
    end
    drain1();
  endtask

  task automatic test_idle_and_start_in_run();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 3; i++) begin
      a1 = 20'($urandom_range(1, 1000)); b1 = 18'($urandom_range(1, 1000));
      z1_d = '0; iv1 = 1; tick(); iv1 = 0; tick();
    end
    tests++;
    if (s1 !== 16'd0 || e1 !== 16'd0 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignore: s=%0d e=%0d busy=%b required 0 0 0", s1, e1, busy1);
    end
    pulse_start1();
    for (int i = 0; i < 2; i++) begin
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
      a = 20'($urandom_range(0, 20'hFFFFF));
      b = 18'($urandom_range(0, 18'h3FFFF));
      beat1(a, b, P_W'(a) * P_W'(b));
    end
    tick();
    start1 = 1;
    beat1(20'd11, 18'd13, 38'd143);
    start1 = 0;
    tick();
    tests++;
    if (s1 !== 16'd3 || busy1 !== 1'b1) begin
      fails++;
      $display("FAIL start_in_run: s=%0d busy=%b required 3 1", s1, busy1);
    end
    drain1();
  endtask

  task automatic test_stop_latency3();
    pulse_start3();
    beat3(20'd4, 18'd6, 38'd24);
    a3 = 20'd9; b3 = 18'd9; z3_d = 38'd80; iv3 = 1; stop3 = 1;
    tick();
    iv3 = 0; stop3 = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if (done3 !== (k == 3) || busy3 !== (k != 3)) begin
        fails++;
        $display("FAIL stop_l3_timing: cycle %0d after stop done=%b busy=%b required %b %b",
                 k, done3, busy3, (k == 3), (k != 3));
      end
    end
    tests++;
    if (s3 !== 4'd2 || e3 !== 4'd1 || fa3 !== 20'd9 || fe3 !== 38'd81 || fz3 !== 38'd80) begin
      fails++;
      $display("FAIL stop_l3_counts: s=%0d e=%0d a=%0d exp=%0d z=%0d required 2 1 9 81 80",
               s3, e3, fa3, fe3, fz3);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_start3();
    beat3(20'd5, 18'd5, 38'd1);
    beat3(20'd6, 18'd6, 38'd2);
    tick();
    reset = 1;
    tick();
    reset = 0;
    tests++;
    if ({busy3, done3, flag3, s3, e3, fa3, fb3, fz3, fe3} !== '0) begin
      fails++;
      $display("FAIL reset_mid_run: busy=%b done=%b flag=%b s=%0d e=%0d required all 0",
               busy3, done3, flag3, s3, e3);
    end
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (s3 !== 4'd0 || e3 !== 4'd0 || busy3 !== 1'b0) begin
      fails++;
      $display("FAIL reset_flush: s=%0d e=%0d busy=%b required 0 0 0", s3, e3, busy3);
    end
  endtask

  task automatic test_saturate();
    pulse_start3();
    for (int i = 0; i < 20; i++) beat3(20'd1, 18'd1, 38'd0);
    drain3();
    tests++;
    if (s3 !== 4'hF || e3 !== 4'hF || flag3 !== 1'b1 || fe3 !== 38'd1 || fz3 !== 38'd0) begin
      fails++;
      $display("FAIL saturate: s=%0d e=%0d flag=%b exp=%0d z=%0d required 15 15 1 1 0",
               s3, e3, flag3, fe3, fz3);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_max_operands();
    test_multi_err();
    test_idle_and_start_in_run();
    test_stop_latency3();
    test_reset_mid_run();
    test_saturate();
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d beats never compared, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
